pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf_pkg.sv | 15 +
 rtl/pipe_sat_cnt.sv | 30 +++
 rtl/pipe_stage_buf.sv | 121 ++++++++++++
 tb/tb_pipe_stage_buf.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline package: stage-buffer state encoding and default widths.
// Reused by the IF/ID, ID/EX and MEM/WB buffer instances.
package pipe_stage_buf_pkg;

   localparam int DATA_W_DEF = 256;
   localparam int CTRL_W_DEF = 8;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } buf_st_t;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating counter for flush statistics.
// Adds 0..2 per cycle and sticks at all-ones.
module pipe_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   inc,
   output logic [W-1:0] cnt
);

   localparam int SW = ((W > 2) ? W : 2) + 1;

   logic [SW-1:0] sum;
   logic [SW-1:0] lim;

   assign sum = SW'(cnt) + SW'(inc);
   assign lim = SW'({W{1'b1}});

   // accumulate, clamping at the maximum code
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (sum > lim)
         cnt <= '1;
      else
         cnt <= sum[W-1:0];
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry in-order pipeline buffer (head + skid) with flush kill.
// Registered in_ready; bubbles present zero control flags.
module pipe_stage_buf
   import pipe_stage_buf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  flush_cnt
);

   buf_st_t st, st_nx;

   logic [DATA_W-1:0] head_data, skid_data;
   logic [CTRL_W-1:0] head_ctrl, skid_ctrl;

   logic acc, pop;
   logic ld_head_in, ld_skid_in, ld_head_skid;
   logic [1:0] kill_n;

   assign acc       = in_valid & in_ready;
   assign out_valid = (st != ST_EMPTY);
   assign pop       = out_valid & out_ready;
   assign occupancy = st;
   assign out_data  = head_data;
   assign out_ctrl  = out_valid ? head_ctrl : '0;
   assign kill_n    = flush ? occupancy : 2'd0;

   // next state and entry-move strobes; flush overrides everything
   always_comb begin
      st_nx        = st;
      ld_head_in   = 1'b0;
      ld_skid_in   = 1'b0;
      ld_head_skid = 1'b0;
      if (flush) begin
         st_nx = ST_EMPTY;
      end else begin
         unique case (st)
            ST_EMPTY: begin
               if (acc) begin
                  st_nx      = ST_ONE;
                  ld_head_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (acc && pop) begin
                  ld_head_in = 1'b1;
               end else if (acc) begin
                  st_nx      = ST_TWO;
                  ld_skid_in = 1'b1;
               end else if (pop) begin
                  st_nx = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  st_nx        = ST_ONE;
                  ld_head_skid = 1'b1;
               end
            end
            default: st_nx = ST_EMPTY;
         endcase
      end
   end

   // state register and registered ready
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st       <= ST_EMPTY;
         in_ready <= 1'b1;
      end else begin
         st       <= st_nx;
         in_ready <= (st_nx != ST_TWO);
      end
   end

   // head and skid entry storage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_data <= '0;
         head_ctrl <= '0;
         skid_data <= '0;
         skid_ctrl <= '0;
      end else begin
         if (ld_head_in) begin
            head_data <= in_data;
            head_ctrl <= in_ctrl;
         end else if (ld_head_skid) begin
            head_data <= skid_data;
            head_ctrl <= skid_ctrl;
         end
         if (ld_skid_in) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
         end
      end
   end

   pipe_sat_cnt #(
      .W (CNT_W)
   ) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (kill_n),
      .cnt (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf.
// Small widths; CNT_W=2 so counter saturation is reachable.
module tb_pipe_stage_buf;

   localparam int DW = 16;
   localparam int CW = 8;
   localparam int NW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [1:0]    occupancy;
   logic [NW-1:0] flush_cnt;

   int checks = 0;
   int errors = 0;

   pipe_stage_buf #(
      .DATA_W (DW),
      .CTRL_W (CW),
      .CNT_W  (NW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .occupancy (occupancy),
      .flush_cnt (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v,
                        input logic [DW-1:0] d,
                        input logic [CW-1:0] c);
      in_valid = v;
      in_data  = d;
      in_ctrl  = c;
   endtask

   logic [DW-1:0] sd [3];
   logic [CW-1:0] sc [3];

   initial begin
      sd[0] = 16'hA001; sd[1] = 16'hB002; sd[2] = 16'hC003;
      sc[0] = 8'h11;    sc[1] = 8'h22;    sc[2] = 8'h44;

      rst       = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive(1'b1, 16'h5555, 8'hFF);
      step();
      step();
      check("rst_ov",  32'(out_valid), 32'd0);
      check("rst_ir",  32'(in_ready),  32'd1);
      check("rst_occ", 32'(occupancy), 32'd0);
      check("rst_fc",  32'(flush_cnt), 32'd0);
      check("rst_oc",  32'(out_ctrl),  32'd0);
      check("rst_od",  32'(out_data),  32'd0);

      // streaming, first accept on first edge after release
      rst       = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, sd[i], sc[i]);
         step();
         check("str_od",  32'(out_data),  32'(sd[i]));
         check("str_oc",  32'(out_ctrl),  32'(sc[i]));
         check("str_occ", 32'(occupancy), 32'd1);
         check("str_ir",  32'(in_ready),  32'd1);
      end
      drive(1'b0, 16'h0, 8'h0);
      step();
      check("drain_ov",  32'(out_valid), 32'd0);
      check("drain_oc",  32'(out_ctrl),  32'd0);
      check("drain_od",  32'(out_data),  32'(sd[2]));
      check("drain_occ", 32'(occupancy), 32'd0);

      // backpressure
      out_ready = 1'b0;
      drive(1'b1, sd[0], sc[0]);
      step();
      check("bp1_occ", 32'(occupancy), 32'd1);
      drive(1'b1, sd[1], sc[1]);
      step();
      check("bp2_occ", 32'(occupancy), 32'd2);
      check("bp2_ir",  32'(in_ready),  32'd0);
      check("bp2_od",  32'(out_data),  32'(sd[0]));
      drive(1'b1, sd[2], sc[2]);
      step();
      check("bp3_occ", 32'(occupancy), 32'd2);
      check("bp3_od",  32'(out_data),  32'(sd[0]));
      out_ready = 1'b1;
      step();
      check("bp4_od",  32'(out_data),  32'(sd[1]));
      check("bp4_oc",  32'(out_ctrl),  32'(sc[1]));
      check("bp4_occ", 32'(occupancy), 32'd1);
      check("bp4_ir",  32'(in_ready),  32'd1);
      step();
      check("bp5_od",  32'(out_data),  32'(sd[2]));
      check("bp5_occ", 32'(occupancy), 32'd1);
      drive(1'b0, 16'h0, 8'h0);
      step();
      check("bp6_ov",  32'(out_valid), 32'd0);

      // flush at occupancy 2 with input offered
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, sd[0], sc[0]);
         step();
         drive(1'b1, sd[1], sc[1]);
         step();
         check("fl_pre_occ", 32'(occupancy), 32'd2);
         flush = 1'b1;
         drive(1'b1, sd[2], sc[2]);
         step();
         flush = 1'b0;
         drive(1'b0, 16'h0, 8'h0);
         check("fl_ov",  32'(out_valid), 32'd0);
         check("fl_oc",  32'(out_ctrl),  32'd0);
         check("fl_occ", 32'(occupancy), 32'd0);
         check("fl_ir",  32'(in_ready),  32'd1);
         check("fl_cnt", 32'(flush_cnt), (k == 0) ? 32'd2 : 32'd3);
      end
      step();
      check("fl_hold", 32'(flush_cnt), 32'd3);

      // async reset mid-cycle at occupancy 2
      drive(1'b1, sd[0], sc[0]);
      step();
      drive(1'b1, sd[1], sc[1]);
      step();
      check("ar_pre", 32'(occupancy), 32'd2);
      #2;
      rst = 1'b0;
      #1;
      check("ar_occ", 32'(occupancy), 32'd0);
      check("ar_ov",  32'(out_valid), 32'd0);
      check("ar_ir",  32'(in_ready),  32'd1);
      check("ar_fc",  32'(flush_cnt), 32'd0);
      check("ar_od",  32'(out_data),  32'd0);
      check("ar_oc",  32'(out_ctrl),  32'd0);
      #1;
      rst = 1'b1;
      drive(1'b1, sd[2], sc[2]);
      step();
      check("ar_first_od",  32'(out_data),  32'(sd[2]));
      check("ar_first_occ", 32'(occupancy), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
